mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Arbitrates the pipelined processor's single shared memory port between instruction fetch (IF stage) and data access (MEM stage, driven from the EX/MEM pipeline register outputs). It sequences each access through a request/acknowledge handshake with memory and produces stall signals that freeze the pipeline while an access is outstanding. A timeout guards against a memory that never acknowledges.

## Interface
- TIMEOUT, 255: cycles without `mem_ack` before an access is aborted; must be ≤ 2^CNT_W − 1
- CNT_W, 8: wait-counter width
- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-low reset
- if_req  in  1  fetch request, held until `if_ack` or flush
- if_addr  in  32  fetch address
- if_flush  in  1  discard any in-flight fetch (branch/jump redirect)
- if_rdata  out  32  fetched instruction, valid while `if_ack`
- if_ack  out  1  one-cycle fetch-complete pulse
- fetch_stall  out  1  `if_req & ~if_ack` (combinational)
- d_rd  in  1  load request (EX/MEM MemReadEn)
- d_wr  in  1  store request (EX/MEM MemWriteEn)
- d_addr  in  32  data address (EX/MEM ALU result)
- d_wdata  in  32  store data (EX/MEM readData2)
- d_rdata  out  32  load data, valid while `d_ack`
- d_ack  out  1  one-cycle data-complete pulse
- stall  out  1  `(d_rd | d_wr) & ~d_ack` (combinational); freezes PC and all pipeline registers
- mem_req, mem_we  out  1 each  memory request / write enable (registered)
- mem_addr, mem_wdata  out  32 each  memory address / write data (registered)
- mem_rdata  in  32  memory read data, valid with `mem_ack`
- mem_ack  in  1  memory completion, one cycle
- timeout_err  out  1  sticky error flag

## Operation
- States: IDLE, DATA, FETCH, RESP.
- IDLE: if `d_rd|d_wr` → capture `d_addr`, `d_wdata`, `mem_we=d_wr`, assert `mem_req`, go to DATA. Else if `if_req & ~if_flush` → capture `if_addr`, `mem_we=0`, assert `mem_req`, go to FETCH. Else stay.
- Priority: data always beats fetch when both are present in IDLE; the older instruction must retire first. `d_rd & d_wr` together is treated as a write.
- DATA/FETCH: `mem_req`, `mem_we`, `mem_addr`, `mem_wdata` stay stable until `mem_ack`. On `mem_ack`: drop `mem_req`, latch `mem_rdata` into `d_rdata`/`if_rdata` (writes latch 0 into `d_rdata`), pulse the matching ack next cycle, go to RESP.
- Flush: `if_flush` seen in any cycle of FETCH sets a discard flag. The fetch still completes on the memory side, but `if_ack` is suppressed and `if_rdata` is left unchanged. The flag clears in RESP.
- RESP: one cycle in which `d_ack` or `if_ack` is high; no new request is issued. Go to IDLE. This cycle lets the pipeline advance, so the next IDLE sees new EX/MEM contents and no access is issued twice.
- Timeout: wait counter is cleared on entry to DATA/FETCH and increments each cycle without `mem_ack`. When it equals TIMEOUT: set `timeout_err`, drop `mem_req`, drive the matching ack in RESP with rdata = 0, go to RESP. `timeout_err` clears only on reset.
- Counter saturates and never wraps.

## Timing
- Reset (`reset=0` at a rising edge): state = IDLE; `mem_req`, `mem_we`, `if_ack`, `d_ack`, `timeout_err` = 0; `mem_addr`, `mem_wdata`, `if_rdata`, `d_rdata` = 0; counter = 0. Reset mid-access abandons the access, and memory must tolerate `mem_req` dropping.
- Data request present in IDLE cycle N → `mem_req=1` in cycle N+1.
- `mem_ack` in cycle M → ack pulse and rdata in M+1 (RESP) → IDLE in M+2.
- Minimum access with `mem_ack` in the first request cycle: 3 cycles from IDLE back to IDLE. `stall` stays high through cycle M and is low in M+1.
- `mem_ack` arriving in IDLE or RESP is ignored.
- `mem_ack` in the same cycle the counter reaches TIMEOUT: treated as a normal completion, and `timeout_err` is not set.

## Test plan
- Load: `d_rd=1`, `d_addr=0x100`, memory acks 2 cycles after `mem_req` with `0xDEADBEEF` → `mem_we=0`, `mem_addr=0x100`; `d_ack` pulses once with `d_rdata=0xDEADBEEF`; `stall` is high for exactly 4 cycles.
- Simultaneous requests: `d_wr=1` (`0x200`, `0x12345678`) and `if_req=1` (`0x40`) in the same IDLE cycle → store issued first (`mem_we=1`); fetch issued on the first IDLE after RESP; `if_ack` follows `d_ack` by at least 3 cycles.
- Flush: `if_flush` pulsed in the 2nd cycle of FETCH → `mem_ack` is consumed, `if_ack` never asserts, `if_rdata` is unchanged, FSM returns to IDLE.
- Timeout: TIMEOUT=4 and memory never acks a load → `mem_req` drops after 4 wait cycles; `d_ack=1` with `d_rdata=0`; `timeout_err=1` and stays set across later transactions.
- Reset mid-access: `reset=0` during DATA → next cycle all outputs are 0 and state is IDLE; a later load completes normally.
- Back-to-back: store is followed immediately by a load in the next EX/MEM slot → two distinct `mem_req` transactions with no duplicate issue of the store.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data access, with
// request/acknowledge sequencing, pipeline stall outputs and an access timeout.
module mem_port_arbiter #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic        clock_i,
  input  logic        reset_ni,

  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  input  logic        if_flush_i,
  output logic [31:0] if_rdata_o,
  output logic        if_ack_o,
  output logic        fetch_stall_o,

  input  logic        d_rd_i,
  input  logic        d_wr_i,
  input  logic [31:0] d_addr_i,
  input  logic [31:0] d_wdata_i,
  output logic [31:0] d_rdata_o,
  output logic        d_ack_o,
  output logic        stall_o,

  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_ack_i,

  output logic        timeout_err_o
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] DATA  = 2'd1;
  localparam logic [1:0] FETCH = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic [1:0]       state_q, state_d;
  logic             memReq_q, memReq_d;
  logic             memWe_q, memWe_d;
  logic [31:0]      memAddr_q, memAddr_d;
  logic [31:0]      memWdata_q, memWdata_d;
  logic [31:0]      ifRdata_q, ifRdata_d;
  logic [31:0]      dRdata_q, dRdata_d;
  logic             ifAck_q, ifAck_d;
  logic             dAck_q, dAck_d;
  logic             timeoutErr_q, timeoutErr_d;
  logic             discard_q, discard_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic dReq;
  logic inAccess;
  logic timeoutHit;
  logic dropFetch;

  assign dReq       = d_rd_i | d_wr_i;
  assign inAccess   = (state_q == DATA) || (state_q == FETCH);
  // A memory ack in the limit cycle wins over the timeout.
  assign timeoutHit = inAccess && !mem_ack_i && (cnt_q == CNT_LIMIT);
  assign dropFetch  = discard_q | if_flush_i;

  always_comb begin
    state_d      = state_q;
    memReq_d     = memReq_q;
    memWe_d      = memWe_q;
    memAddr_d    = memAddr_q;
    memWdata_d   = memWdata_q;
    ifRdata_d    = ifRdata_q;
    dRdata_d     = dRdata_q;
    ifAck_d      = 1'b0;
    dAck_d       = 1'b0;
    timeoutErr_d = timeoutErr_q;
    discard_d    = discard_q;
    cnt_d        = cnt_q;

    case (state_q)
      IDLE: begin
        // Data first: the older instruction in EX/MEM must retire before the next fetch.
        if (dReq) begin
          state_d    = DATA;
          memReq_d   = 1'b1;
          memWe_d    = d_wr_i;
          memAddr_d  = d_addr_i;
          memWdata_d = d_wdata_i;
          cnt_d      = '0;
        end else if (if_req_i && !if_flush_i) begin
          state_d   = FETCH;
          memReq_d  = 1'b1;
          memWe_d   = 1'b0;
          memAddr_d = if_addr_i;
          cnt_d     = '0;
          discard_d = 1'b0;
        end
      end

      DATA: begin
        if (mem_ack_i) begin
          state_d  = RESP;
          memReq_d = 1'b0;
          memWe_d  = 1'b0;
          dAck_d   = 1'b1;
          dRdata_d = memWe_q ? 32'h0 : mem_rdata_i;
        end else if (timeoutHit) begin
          state_d      = RESP;
          memReq_d     = 1'b0;
          memWe_d      = 1'b0;
          dAck_d       = 1'b1;
          dRdata_d     = 32'h0;
          timeoutErr_d = 1'b1;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      FETCH: begin
        discard_d = dropFetch;
        // A redirected fetch still finishes on the bus but is never reported.
        if (mem_ack_i) begin
          state_d  = RESP;
          memReq_d = 1'b0;
          if (!dropFetch) begin
            ifAck_d   = 1'b1;
            ifRdata_d = mem_rdata_i;
          end
        end else if (timeoutHit) begin
          state_d      = RESP;
          memReq_d     = 1'b0;
          timeoutErr_d = 1'b1;
          if (!dropFetch) begin
            ifAck_d   = 1'b1;
            ifRdata_d = 32'h0;
          end
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      RESP: begin
        state_d   = IDLE;
        discard_d = 1'b0;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (!reset_ni) begin
      state_q      <= IDLE;
      memReq_q     <= 1'b0;
      memWe_q      <= 1'b0;
      memAddr_q    <= 32'h0;
      memWdata_q   <= 32'h0;
      ifRdata_q    <= 32'h0;
      dRdata_q     <= 32'h0;
      ifAck_q      <= 1'b0;
      dAck_q       <= 1'b0;
      timeoutErr_q <= 1'b0;
      discard_q    <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      memReq_q     <= memReq_d;
      memWe_q      <= memWe_d;
      memAddr_q    <= memAddr_d;
      memWdata_q   <= memWdata_d;
      ifRdata_q    <= ifRdata_d;
      dRdata_q     <= dRdata_d;
      ifAck_q      <= ifAck_d;
      dAck_q       <= dAck_d;
      timeoutErr_q <= timeoutErr_d;
      discard_q    <= discard_d;
      cnt_q        <= cnt_d;
    end
  end

  assign mem_req_o     = memReq_q;
  assign mem_we_o      = memWe_q;
  assign mem_addr_o    = memAddr_q;
  assign mem_wdata_o   = memWdata_q;
  assign if_rdata_o    = ifRdata_q;
  assign if_ack_o      = ifAck_q;
  assign d_rdata_o     = dRdata_q;
  assign d_ack_o       = dAck_q;
  assign timeout_err_o = timeoutErr_q;

  assign fetch_stall_o = if_req_i & ~ifAck_q;
  assign stall_o       = dReq & ~dAck_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: the bench plays pipeline and memory,
// and predicts results from a word-level memory image and transaction rules.
module tb_mem_port_arbiter;

  localparam int TIMEOUT_P  = 4;
  localparam int CNT_W_P    = 8;
  localparam int KIND_LOAD  = 0;
  localparam int KIND_STORE = 1;
  localparam int KIND_FETCH = 2;
  localparam int KIND_RW    = 3;
  localparam int NEVER      = 1000;

  logic        clock = 1'b0;
  logic        resetN;
  logic        ifReq, ifFlush, dRd, dWr, memAck;
  logic [31:0] ifAddr, dAddr, dWdata, memRdata;
  logic [31:0] ifRdata, dRdata, memAddr, memWdata;
  logic        ifAck, fetchStall, dAck, stall, memReq, memWe, timeoutErr;

  mem_port_arbiter #(.TIMEOUT(TIMEOUT_P), .CNT_W(CNT_W_P)) dut (
    .clock_i      (clock),
    .reset_ni     (resetN),
    .if_req_i     (ifReq),
    .if_addr_i    (ifAddr),
    .if_flush_i   (ifFlush),
    .if_rdata_o   (ifRdata),
    .if_ack_o     (ifAck),
    .fetch_stall_o(fetchStall),
    .d_rd_i       (dRd),
    .d_wr_i       (dWr),
    .d_addr_i     (dAddr),
    .d_wdata_i    (dWdata),
    .d_rdata_o    (dRdata),
    .d_ack_o      (dAck),
    .stall_o      (stall),
    .mem_req_o    (memReq),
    .mem_we_o     (memWe),
    .mem_addr_o   (memAddr),
    .mem_wdata_o  (memWdata),
    .mem_rdata_i  (memRdata),
    .mem_ack_i    (memAck),
    .timeout_err_o(timeoutErr)
  );

  always #5 clock = ~clock;

  int          vectors     = 0;
  int          miscompares = 0;
  int          cycle       = 0;
  int          lastDAckCycle;
  int          lastIfAckCycle;
  bit   [31:0] busMem [256];
  bit   [31:0] refMem [256];
  logic [31:0] expIfRdata;
  logic        expErr;

  task automatic tick();
    @(posedge clock);
    #1;
    cycle++;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // One complete access from an IDLE cycle through RESP to the following IDLE.
  task automatic applyStimulus(input int kind, input logic [31:0] addr, input logic [31:0] wdata,
                               input int lat, input int flushAt, input bit holdFetch,
                               input logic [31:0] fetchAddr);
    bit          isData, isWrite, acked, flushed;
    int          reqCycles, stallCycles;
    logic [7:0]  idx;
    logic [31:0] expRd;
    isData      = (kind != KIND_FETCH);
    isWrite     = (kind == KIND_STORE) || (kind == KIND_RW);
    idx         = addr[9:2];
    acked       = 1'b0;
    flushed     = 1'b0;
    reqCycles   = 0;
    stallCycles = 0;
    if (isData) begin
      dRd    = (kind == KIND_LOAD) || (kind == KIND_RW);
      dWr    = isWrite;
      dAddr  = addr;
      dWdata = wdata;
      if (holdFetch) begin
        ifReq  = 1'b1;
        ifAddr = fetchAddr;
      end
    end else begin
      ifReq  = 1'b1;
      ifAddr = addr;
    end
    #1;
    checkOutput("stall_issue", 32'(stall), 32'(isData));
    checkOutput("fetch_stall_issue", 32'(fetchStall), 32'(ifReq));
    if (stall) stallCycles++;
    tick();

    for (int c = 0; c <= TIMEOUT_P; c++) begin
      checkOutput("mem_req_hold", 32'(memReq), 32'd1);
      checkOutput("mem_addr", memAddr, addr);
      checkOutput("mem_we", 32'(memWe), 32'(isWrite));
      if (isData) checkOutput("mem_wdata", memWdata, wdata);
      checkOutput("stall_wait", 32'(stall), 32'(isData));
      checkOutput("fetch_stall_wait", 32'(fetchStall), 32'(ifReq));
      checkOutput("timeout_err_wait", 32'(timeoutErr), 32'(expErr));
      if (stall) stallCycles++;
      reqCycles++;
      if (!isData && c == flushAt) begin
        ifFlush = 1'b1;
        ifReq   = 1'b0;
        flushed = 1'b1;
      end
      if (c == lat) begin
        memAck = 1'b1;
        if (memWe) begin
          busMem[memAddr[9:2]] = memWdata;
          memRdata = $urandom;
        end else begin
          memRdata = busMem[memAddr[9:2]];
        end
        acked = 1'b1;
      end
      tick();
      memAck  = 1'b0;
      ifFlush = 1'b0;
      if (acked) break;
    end

    // RESP cycle
    if (!acked) expErr = 1'b1;
    checkOutput("mem_req_resp", 32'(memReq), 32'd0);
    checkOutput("timeout_err_resp", 32'(timeoutErr), 32'(expErr));
    if (isData) begin
      expRd = (!acked || isWrite) ? 32'h0 : 32'(refMem[idx]);
      checkOutput("d_ack_resp", 32'(dAck), 32'd1);
      checkOutput("d_rdata", dRdata, expRd);
      checkOutput("stall_resp", 32'(stall), 32'd0);
      checkOutput("if_ack_quiet", 32'(ifAck), 32'd0);
      checkOutput("stall_cycles", 32'(stallCycles), 32'(reqCycles + 1));
      if (isWrite && acked) refMem[idx] = wdata;
      if (dAck) lastDAckCycle = cycle;
    end else begin
      if (!flushed) expIfRdata = acked ? 32'(refMem[idx]) : 32'h0;
      checkOutput("if_ack_resp", 32'(ifAck), 32'(!flushed));
      checkOutput("if_rdata", ifRdata, expIfRdata);
      checkOutput("d_ack_quiet", 32'(dAck), 32'd0);
      if (ifAck) lastIfAckCycle = cycle;
    end
    tick();

    // Following IDLE: request inputs were still held through RESP, nothing may be reissued.
    checkOutput("no_reissue", 32'(memReq), 32'd0);
    checkOutput("d_ack_pulse", 32'(dAck), 32'd0);
    checkOutput("if_ack_pulse", 32'(ifAck), 32'd0);
    dRd = 1'b0;
    dWr = 1'b0;
    if (!(isData && holdFetch)) ifReq = 1'b0;
  endtask

  initial begin
    logic [31:0] v;
    resetN   = 1'b0;
    ifReq    = 1'b0;
    ifFlush  = 1'b0;
    dRd      = 1'b0;
    dWr      = 1'b0;
    memAck   = 1'b0;
    ifAddr   = 32'h0;
    dAddr    = 32'h0;
    dWdata   = 32'h0;
    memRdata = 32'h0;
    expErr     = 1'b0;
    expIfRdata = 32'h0;
    lastDAckCycle  = -100;
    lastIfAckCycle = -100;
    for (int i = 0; i < 256; i++) begin
      v = $urandom;
      busMem[i] = v;
      refMem[i] = v;
    end
    busMem[8'h40] = 32'hDEAD_BEEF;
    refMem[8'h40] = 32'hDEAD_BEEF;

    tick();
    tick();
    checkOutput("rst_mem_req", 32'(memReq), 32'd0);
    checkOutput("rst_mem_we", 32'(memWe), 32'd0);
    checkOutput("rst_mem_addr", memAddr, 32'h0);
    checkOutput("rst_mem_wdata", memWdata, 32'h0);
    checkOutput("rst_if_rdata", ifRdata, 32'h0);
    checkOutput("rst_d_rdata", dRdata, 32'h0);
    checkOutput("rst_acks", {30'h0, ifAck, dAck}, 32'h0);
    checkOutput("rst_timeout_err", 32'(timeoutErr), 32'd0);
    resetN = 1'b1;
    tick();

    // Load with ack two cycles after the request appears.
    applyStimulus(KIND_LOAD, 32'h0000_0100, 32'h0, 2, -1, 1'b0, 32'h0);

    // Store and fetch in the same IDLE cycle: store first, fetch after RESP.
    lastDAckCycle  = -100;
    lastIfAckCycle = -100;
    applyStimulus(KIND_STORE, 32'h0000_0200, 32'h1234_5678, 1, -1, 1'b1, 32'h0000_0040);
    applyStimulus(KIND_FETCH, 32'h0000_0040, 32'h0, 0, -1, 1'b0, 32'h0);
    checkOutput("if_ack_gap", 32'((lastIfAckCycle - lastDAckCycle) >= 3), 32'd1);

    // Fetch redirected in its second cycle.
    applyStimulus(KIND_FETCH, 32'h0000_0080, 32'h0, 3, 1, 1'b0, 32'h0);

    // Simultaneous read and write enables behave as a store.
    applyStimulus(KIND_RW, 32'h0000_0240, 32'hA5A5_5A5A, 0, -1, 1'b0, 32'h0);
    applyStimulus(KIND_LOAD, 32'h0000_0240, 32'h0, 0, -1, 1'b0, 32'h0);

    // Ack in the same cycle the wait count hits the limit is a normal completion.
    applyStimulus(KIND_LOAD, 32'h0000_0180, 32'h0, TIMEOUT_P, -1, 1'b0, 32'h0);

    // Stray ack while idle is ignored.
    memAck   = 1'b1;
    memRdata = $urandom;
    tick();
    memAck = 1'b0;
    checkOutput("idle_ack_d", 32'(dAck), 32'd0);
    checkOutput("idle_ack_if", 32'(ifAck), 32'd0);
    checkOutput("idle_ack_req", 32'(memReq), 32'd0);

    // Memory never answers a load, then an ordinary store keeps the error flag.
    applyStimulus(KIND_LOAD, 32'h0000_0140, 32'h0, NEVER, -1, 1'b0, 32'h0);
    applyStimulus(KIND_STORE, 32'h0000_0144, 32'hCAFE_F00D, 1, -1, 1'b0, 32'h0);
    applyStimulus(KIND_FETCH, 32'h0000_0148, 32'h0, NEVER, -1, 1'b0, 32'h0);

    // Reset in the middle of a data access.
    dRd   = 1'b1;
    dAddr = 32'h0000_0300;
    tick();
    tick();
    checkOutput("mem_req_pre_reset", 32'(memReq), 32'd1);
    resetN = 1'b0;
    tick();
    checkOutput("mid_rst_mem_req", 32'(memReq), 32'd0);
    checkOutput("mid_rst_mem_addr", memAddr, 32'h0);
    checkOutput("mid_rst_d_rdata", dRdata, 32'h0);
    checkOutput("mid_rst_if_rdata", ifRdata, 32'h0);
    checkOutput("mid_rst_timeout_err", 32'(timeoutErr), 32'd0);
    expErr     = 1'b0;
    expIfRdata = 32'h0;
    dRd    = 1'b0;
    resetN = 1'b1;
    tick();
    checkOutput("post_rst_idle", 32'(memReq), 32'd0);
    applyStimulus(KIND_LOAD, 32'h0000_0300, 32'h0, 1, -1, 1'b0, 32'h0);

    // Store followed immediately by a load of the same word.
    applyStimulus(KIND_STORE, 32'h0000_02C0, 32'h0BAD_CAFE, 0, -1, 1'b0, 32'h0);
    applyStimulus(KIND_LOAD, 32'h0000_02C0, 32'h0, 1, -1, 1'b0, 32'h0);

    // Random mix of loads, stores and fetches, some fetches redirected.
    for (int t = 0; t < 60; t++) begin
      int          kind;
      int          lat;
      int          fl;
      logic [31:0] a;
      kind = int'($urandom_range(0, 3));
      lat  = int'($urandom_range(0, TIMEOUT_P));
      fl   = -1;
      if (kind == KIND_FETCH && $urandom_range(0, 2) == 0) fl = int'($urandom_range(0, lat));
      a = ($urandom & 32'hFFFF_0000) | (32'($urandom_range(0, 15)) << 2);
      applyStimulus(kind, a, $urandom, lat, fl, 1'b0, 32'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
